// File: rtl/sap1_step_sequencer.sv
// sap1_step_sequencer
//
// Sequential front end of the SAP1 control path. Holds the microstep
// counter, the instruction register and the latched ALU flags that feed
// the combinational instruction decoder, and consumes the decoder's
// control word (II, EL, ADV, HLT) to advance, restart or halt execution.
// Every output is registered, so the control word for step N is valid
// while o_step == N and takes effect at the following rising edge.
//
// Optional feature macro: SINGLE_STEP_EN
//   defined   : an active cycle also needs i_step_req; o_step_ack pulses
//               for one cycle after each accepted step.
//   undefined : i_step_req / o_step_ack are absent; free-runs on i_run_en.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_run_en              global enable, low freezes all state
//   i_bus                 bus word, opcode in upper bits, sampled on i_ii
//   i_alu_result/_carry   ALU result and carry, sampled on i_el
//   i_ii/i_el/i_adv/i_hlt control word bits from the decoder
//   o_instruction         opcode to the decoder
//   o_operand             immediate/address field
//   o_step                current microstep
//   o_zero/o_carry/o_odd  latched ALU flags
//   o_halted              halt indicator
//   o_step_overflow       sticky: step wrapped without ADV
//   o_instr_count         retired instructions, saturating
//   i_step_req/o_step_ack single-step handshake (SINGLE_STEP_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | executing microsteps on every active cycle
// HALT  | terminal; all inputs ignored, outputs hold until i_reset

module sap1_step_sequencer #(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int INSTRUCTION_STEPS = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int COUNT_WIDTH       = 16,
  localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
  localparam int OPERAND_WIDTH    = DATA_WIDTH - INSTRUCTION_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_run_en,
  input  logic [DATA_WIDTH-1:0]        i_bus,
  input  logic [DATA_WIDTH-1:0]        i_alu_result,
  input  logic                         i_alu_carry,
  input  logic                         i_ii,
  input  logic                         i_el,
  input  logic                         i_adv,
  input  logic                         i_hlt,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic [OPERAND_WIDTH-1:0]     o_operand,
  output logic [STEP_WIDTH-1:0]        o_step,
  output logic                         o_zero,
  output logic                         o_carry,
  output logic                         o_odd,
  output logic                         o_halted,
  output logic                         o_step_overflow,
  output logic [COUNT_WIDTH-1:0]       o_instr_count
`ifdef SINGLE_STEP_EN
  ,
  input  logic                         i_step_req,
  output logic                         o_step_ack
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  state_t                         state_q, state_d;
  logic                           active;
  logic [INSTRUCTION_WIDTH-1:0]   instruction_d;
  logic [OPERAND_WIDTH-1:0]       operand_d;
  logic [STEP_WIDTH-1:0]          step_d;
  logic                           zero_d, carry_d, odd_d;
  logic                           overflow_d;
  logic [COUNT_WIDTH-1:0]         count_d;

  always_comb begin
`ifdef SINGLE_STEP_EN
    active = (state_q == RUN) && i_run_en && i_step_req;
`else
    active = (state_q == RUN) && i_run_en;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= RUN;
      o_instruction   <= '0;
      o_operand       <= '0;
      o_step          <= '0;
      o_zero          <= 1'b0;
      o_carry         <= 1'b0;
      o_odd           <= 1'b0;
      o_halted        <= 1'b0;
      o_step_overflow <= 1'b0;
      o_instr_count   <= '0;
`ifdef SINGLE_STEP_EN
      o_step_ack      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      o_instruction   <= instruction_d;
      o_operand       <= operand_d;
      o_step          <= step_d;
      o_zero          <= zero_d;
      o_carry         <= carry_d;
      o_odd           <= odd_d;
      o_halted        <= (state_d == HALT);
      o_step_overflow <= overflow_d;
      o_instr_count   <= count_d;
`ifdef SINGLE_STEP_EN
      o_step_ack      <= active;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    instruction_d = o_instruction;
    operand_d     = o_operand;
    step_d        = o_step;
    zero_d        = o_zero;
    carry_d       = o_carry;
    odd_d         = o_odd;
    overflow_d    = o_step_overflow;
    count_d       = o_instr_count;

    if (active) begin
      // IR and flag loads are independent of the step decision, so they
      // still happen on the same edge that halts.
      if (i_ii) begin
        instruction_d = i_bus[DATA_WIDTH-1 -: INSTRUCTION_WIDTH];
        operand_d     = i_bus[OPERAND_WIDTH-1:0];
      end
      if (i_el) begin
        zero_d  = (i_alu_result == '0);
        carry_d = i_alu_carry;
        odd_d   = i_alu_result[0];
      end

      if (i_hlt) begin
        state_d = HALT;
      end else if (i_adv) begin
        step_d = '0;
        if (o_instr_count != {COUNT_WIDTH{1'b1}}) begin
          count_d = o_instr_count + 1'b1;
        end
      end else if (o_step == LAST_STEP) begin
        // Running off the end of the step table means the decoder never
        // issued ADV for this opcode.
        step_d     = '0;
        overflow_d = 1'b1;
      end else begin
        step_d = o_step + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sap1_step_sequencer.sv
module tb_sap1_step_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset, i_run_en;
  logic [7:0] i_bus, i_alu_result;
  logic       i_alu_carry, i_ii, i_el, i_adv, i_hlt;
  logic [3:0] o_instruction, o_operand;
  logic [2:0] o_step;
  logic       o_zero, o_carry, o_odd, o_halted, o_step_overflow;
  logic [15:0] o_instr_count;
`ifdef SINGLE_STEP_EN
  logic       i_step_req, o_step_ack;
`endif

  int n_chk = 0;
  int n_bad = 0;

  sap1_step_sequencer dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_run_en        (i_run_en),
    .i_bus           (i_bus),
    .i_alu_result    (i_alu_result),
    .i_alu_carry     (i_alu_carry),
    .i_ii            (i_ii),
    .i_el            (i_el),
    .i_adv           (i_adv),
    .i_hlt           (i_hlt),
    .o_instruction   (o_instruction),
    .o_operand       (o_operand),
    .o_step          (o_step),
    .o_zero          (o_zero),
    .o_carry         (o_carry),
    .o_odd           (o_odd),
    .o_halted        (o_halted),
    .o_step_overflow (o_step_overflow),
    .o_instr_count   (o_instr_count)
`ifdef SINGLE_STEP_EN
    ,
    .i_step_req      (i_step_req),
    .o_step_ack      (o_step_ack)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set after return are sampled at the next edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_ctl();
    i_ii = 1'b0; i_el = 1'b0; i_adv = 1'b0; i_hlt = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".instr"}, {28'd0, o_instruction}, 32'h0);
    chk({tag, ".operand"}, {28'd0, o_operand}, 32'h0);
    chk({tag, ".step"}, {29'd0, o_step}, 32'h0);
    chk({tag, ".flags"}, {29'd0, o_zero, o_carry, o_odd}, 32'h0);
    chk({tag, ".halted"}, {31'd0, o_halted}, 32'h0);
    chk({tag, ".ovf"}, {31'd0, o_step_overflow}, 32'h0);
    chk({tag, ".count"}, {16'd0, o_instr_count}, 32'h0);
`ifdef SINGLE_STEP_EN
    chk({tag, ".ack"}, {31'd0, o_step_ack}, 32'h0);
`endif
  endtask

  initial begin
    i_reset = 1'b1; i_run_en = 1'b1; i_bus = 8'h00; i_alu_result = 8'h00;
    i_alu_carry = 1'b0;
    clear_ctl();
`ifdef SINGLE_STEP_EN
    i_step_req = 1'b1;
`endif
    tick();
    tick();
    chk_all_zero("reset");
    i_reset = 1'b0;

    // Fetch: step 0 -> 1, IR load at step 1.
    tick();
    chk("fetch.step1", {29'd0, o_step}, 32'd1);
    i_ii = 1'b1; i_bus = 8'h1E;
    tick();
    clear_ctl();
    chk("ir.step2", {29'd0, o_step}, 32'd2);
    chk("ir.instr", {28'd0, o_instruction}, 32'h1);
    chk("ir.operand", {28'd0, o_operand}, 32'hE);

    // Flags: zero result with carry.
    i_el = 1'b1; i_alu_result = 8'h00; i_alu_carry = 1'b1;
    tick();
    clear_ctl();
    chk("el1.step3", {29'd0, o_step}, 32'd3);
    chk("el1.zco", {29'd0, o_zero, o_carry, o_odd}, 32'b110);

    // ADV at step 3 retires the instruction.
    i_adv = 1'b1;
    tick();
    clear_ctl();
    chk("adv.step0", {29'd0, o_step}, 32'd0);
    chk("adv.count", {16'd0, o_instr_count}, 32'd1);
    chk("adv.ovf", {31'd0, o_step_overflow}, 32'd0);

    tick();
    chk("i2.step1", {29'd0, o_step}, 32'd1);
    i_el = 1'b1; i_alu_result = 8'h03; i_alu_carry = 1'b0;
    tick();
    clear_ctl();
    chk("el2.zco", {29'd0, o_zero, o_carry, o_odd}, 32'b001);
    chk("el2.step2", {29'd0, o_step}, 32'd2);

    // Freeze: run_en low ignores ADV and II.
    i_run_en = 1'b0; i_adv = 1'b1; i_ii = 1'b1; i_bus = 8'hC3;
    repeat (3) tick();
    chk("frz.step", {29'd0, o_step}, 32'd2);
    chk("frz.count", {16'd0, o_instr_count}, 32'd1);
    chk("frz.instr", {28'd0, o_instruction}, 32'h1);
    clear_ctl();
    i_run_en = 1'b1;

    // HLT with ADV at step 2; concurrent II still loads.
    i_hlt = 1'b1; i_adv = 1'b1; i_ii = 1'b1; i_bus = 8'h5A;
    tick();
    clear_ctl();
    chk("hlt.halted", {31'd0, o_halted}, 32'd1);
    chk("hlt.step", {29'd0, o_step}, 32'd2);
    chk("hlt.count", {16'd0, o_instr_count}, 32'd1);
    chk("hlt.instr", {28'd0, o_instruction}, 32'h5);
    chk("hlt.operand", {28'd0, o_operand}, 32'hA);

    // HALT ignores everything.
    i_adv = 1'b1; i_ii = 1'b1; i_bus = 8'hFF; i_el = 1'b1; i_alu_result = 8'h00;
    i_alu_carry = 1'b1;
    repeat (2) tick();
    clear_ctl();
    chk("halt.step", {29'd0, o_step}, 32'd2);
    chk("halt.count", {16'd0, o_instr_count}, 32'd1);
    chk("halt.instr", {28'd0, o_instruction}, 32'h5);
    chk("halt.zco", {29'd0, o_zero, o_carry, o_odd}, 32'b001);
    chk("halt.halted", {31'd0, o_halted}, 32'd1);

    // Reset from HALT.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk_all_zero("rst2");

    // No ADV for 8 active cycles: 1..7 then wrap to 0 with overflow.
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("wrap.step%0d", k), {29'd0, o_step}, (k == 8) ? 32'd0 : k);
      chk($sformatf("wrap.ovf%0d", k), {31'd0, o_step_overflow}, (k == 8) ? 32'd1 : 32'd0);
    end
    chk("wrap.count", {16'd0, o_instr_count}, 32'd0);
    i_adv = 1'b1;
    tick();
    clear_ctl();
    chk("sticky.ovf", {31'd0, o_step_overflow}, 32'd1);
    chk("sticky.count", {16'd0, o_instr_count}, 32'd1);
    chk("sticky.step", {29'd0, o_step}, 32'd0);

`ifdef SINGLE_STEP_EN
    tick();
    chk("ss.step1", {29'd0, o_step}, 32'd1);
    i_step_req = 1'b0;
    repeat (10) tick();
    chk("ss.hold", {29'd0, o_step}, 32'd1);
    chk("ss.noack", {31'd0, o_step_ack}, 32'd0);
    i_step_req = 1'b1;
    tick();
    i_step_req = 1'b0;
    chk("ss.step2", {29'd0, o_step}, 32'd2);
    chk("ss.ack", {31'd0, o_step_ack}, 32'd1);
    tick();
    chk("ss.ackdrop", {31'd0, o_step_ack}, 32'd0);
    chk("ss.step2b", {29'd0, o_step}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
